uart_transmit: RTL and testbench
================================

UART_TRANSMIT -- requirements
Module: uart_transmit

Interface
REQ-001 Parameter CLKS_PER_BIT, default 2, uart_clock cycles per serial bit; legal range 1..255.
REQ-002 uart_clock  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 data_in  input  8  byte to transmit; sampled only on an accepting edge.
REQ-005 send  input  1  request valid; byte is accepted on a rising edge where send=1 and ready=1.
REQ-006 ready  output  1  high when the one-entry holding register is empty.
REQ-007 serial_data  output  1  registered serial line; idle level 1.
REQ-008 busy  output  1  high while the FSM is in any state other than IDLE.
REQ-009 par  output  1  parity bit of the frame currently being sent, or of the last frame sent.

Function
REQ-010 The frame SHALL be: start bit 0, data bits 0..7 LSB first, parity, one stop bit 1. The frame is 11 bits long.
REQ-011 Parity SHALL be odd: data bits plus the parity bit contain an odd number of ones, so par = ~^data.
REQ-012 Each frame bit SHALL hold serial_data for exactly CLKS_PER_BIT cycles, so one frame lasts 11*CLKS_PER_BIT cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY and STOP. A bit-cycle counter and a 3-bit data index sequence DATA through bits 0..7.
REQ-014 FSM transitions SHALL be:
- IDLE->START when the holding register is full.
- START->DATA, DATA->PARITY (after bit 7) and PARITY->STOP at the end of each bit period.
- STOP->START at the end of the stop period if the holding register is full; otherwise STOP->IDLE.
REQ-015 An accepting edge SHALL write data_in into the holding register and set it full; ready SHALL go low in the following cycle.
REQ-016 Entering START SHALL copy the holding register into a shift register, latch par, and clear the holding register, so ready returns to 1.
REQ-017 Latency: if a byte is accepted at edge k while the FSM is IDLE, serial_data SHALL be 0 (start bit) from edge k+1.
REQ-018 Back-to-back frames: a byte accepted during a frame SHALL start transmission immediately after that frame's stop bit, with no idle cycles.
REQ-019 send while ready=0 SHALL be ignored; the holding register and the frame in progress SHALL remain unchanged.
REQ-020 Changes on data_in after acceptance SHALL NOT affect the frame.
REQ-021 An accept and a holding-register drain can never occur on the same edge, because drain requires full and accept requires empty; no arbitration is needed.
REQ-022 When the FSM is IDLE, serial_data SHALL be 1 and busy SHALL be 0.

Reset
REQ-023 On an edge with rst=0 the block SHALL set: serial_data=1, busy=0, ready=1, par=0, FSM=IDLE, counters=0, holding register empty.
REQ-024 A reset mid-frame SHALL abandon the frame and discard any held byte; the line SHALL return to 1 on that edge.
REQ-025 Reset SHALL have priority over send on the same edge.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state enum, FRAME_BITS=11, DATA_BITS=8 and the parity-sense constant. The matching receiver SHALL reuse this package.
REQ-027 One sub-module, uart_bit_timer (CLKS_PER_BIT down-counter emitting a one-cycle bit_done pulse, restarted by the FSM), SHALL be used; all other logic stays in uart_transmit.

Verification
REQ-028 CLKS_PER_BIT=2, send 0xF7:
- serial_data SHALL be 0,1,1,1,0,1,1,1,1,0,1, each bit for 2 cycles.
- par SHALL be 0.
- busy SHALL be high for 22 cycles, then the line idles at 1.
REQ-029 Send 0x00: the data bits SHALL all be 0, par=1 and the parity bit on the line SHALL be 1. Send 0xFF: par=1.
REQ-030 Send 0xF7, then send 0x55 while the first frame is busy:
- The second start bit SHALL follow the first stop bit directly, giving 44 contiguous cycles.
- ready SHALL rise at the start of the 0x55 frame.
REQ-031 Assert send with 0xAA while ready=0: no extra frame SHALL be produced, and the held byte SHALL be unchanged.
REQ-032 Pull rst low during data bit 3: on the next edge the line SHALL be 1, busy=0 and ready=1, and no stop or parity bit SHALL follow.
REQ-033 CLKS_PER_BIT=1, send 0x01: the line SHALL be 0,1,0,0,0,0,0,0,0,0,1 over 11 cycles with par=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame geometry and parity sense.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

    localparam int   FRAME_BITS = 11;
    localparam int   DATA_BITS  = 8;
    localparam logic PARITY_ODD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Parity bit that makes data plus parity contain an odd number of ones.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter; bit_done_o pulses in the last cycle of each bit period.
// Reloaded by restart_i on every bit boundary; no backpressure.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic restart_i,
    input  logic run_i,
    output logic bit_done_o
);

    localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done_o = run_i && (cnt_q == 8'd0);

endmodule

// File: rtl/uart_transmit.sv
// 8O1 UART transmitter with a one-entry holding register; start bit appears one edge after accept.
// ready is low while the holding register is full; frames run back-to-back when a byte is waiting.
module uart_transmit
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic                 uart_clock,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 send,
    output logic                 ready,
    output logic                 serial_data,
    output logic                 busy,
    output logic                 par
);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 full_q, full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           idx_q, idx_d;
    logic                 par_q, par_d;
    logic                 serial_q, serial_d;
    logic                 bit_done;
    logic                 restart;
    logic                 accept;
    logic                 load;

    // Every bit boundary, including the first start bit out of IDLE, reloads the timer.
    assign restart = ((state_q == ST_IDLE) && full_q) || bit_done;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i     (uart_clock),
        .rst_n_i   (rst),
        .restart_i (restart),
        .run_i     (state_q != ST_IDLE),
        .bit_done_o(bit_done)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        full_d  = full_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        load    = 1'b0;
        accept  = send && !full_q;

        case (state_q)
            ST_IDLE: begin
                if (full_q) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (full_q) begin
                        state_d = ST_START;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Drain needs full and accept needs empty, so these never collide.
        if (load) begin
            shift_d = hold_q;
            par_d   = parity_bit(hold_q);
            full_d  = 1'b0;
        end else if (accept) begin
            hold_d = data_in;
            full_d = 1'b1;
        end

        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shift_d[0];
            ST_PARITY: serial_d = par_d;
            default:   serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge uart_clock) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            full_q   <= 1'b0;
            shift_q  <= '0;
            idx_q    <= 3'd0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            full_q   <= full_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            par_q    <= par_d;
            serial_q <= serial_d;
        end
    end

    assign ready       = !full_q;
    assign serial_data = serial_q;
    assign busy        = (state_q != ST_IDLE);
    assign par         = par_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit at CLKS_PER_BIT=2 (dut) and CLKS_PER_BIT=1 (dut1).
module tb_uart_transmit;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       send;
    logic       ready, serial_data, busy, par;
    logic [7:0] data_in1;
    logic       send1;
    logic       ready1, serial_data1, busy1, par1;

    int n_checks;
    int n_fail;

    uart_transmit #(.CLKS_PER_BIT(2)) dut (
        .uart_clock (clk),
        .rst        (rst),
        .data_in    (data_in),
        .send       (send),
        .ready      (ready),
        .serial_data(serial_data),
        .busy       (busy),
        .par        (par)
    );

    uart_transmit #(.CLKS_PER_BIT(1)) dut1 (
        .uart_clock (clk),
        .rst        (rst),
        .data_in    (data_in1),
        .send       (send1),
        .ready      (ready1),
        .serial_data(serial_data1),
        .busy       (busy1),
        .par        (par1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        send = 1'b1;
        data_in = 8'hAA;
        tick();
        tick();
        n_checks++; if (serial_data !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b expected 1", serial_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_over_send: got %b expected 1", ready); end
        n_checks++; if (par !== 1'b0) begin n_fail++; $display("FAIL reset_par: got %b expected 0", par); end
        n_checks++; if (serial_data1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_dut1: got serial=%b busy=%b expected 1/0", serial_data1, busy1); end
        send = 1'b0;
        rst = 1'b1;
        tick();
        n_checks++; if (ready !== 1'b1 || serial_data !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: got ready=%b serial=%b busy=%b expected 1/1/0", ready, serial_data, busy); end
    endtask

    task automatic test_single_f7();
        logic [10:0] exp;
        exp = 11'b10111101110;
        data_in = 8'hF7;
        send = 1'b1;
        tick();
        send = 1'b0;
        data_in = 8'h00;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL f7_ready_after_accept: got %b expected 0", ready); end
        n_checks++; if (serial_data !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL f7_idle_on_accept_edge: got serial=%b busy=%b expected 1/0", serial_data, busy); end
        for (int i = 0; i < 22; i++) begin
            tick();
            n_checks++; if (serial_data !== exp[i/2]) begin n_fail++; $display("FAIL f7_line cycle %0d: got %b expected %b", i, serial_data, exp[i/2]); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL f7_busy cycle %0d: got %b expected 1", i, busy); end
            if (i == 0) begin
                n_checks++; if (par !== 1'b0) begin n_fail++; $display("FAIL f7_par: got %b expected 0", par); end
                n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL f7_ready_after_start: got %b expected 1", ready); end
            end
        end
        tick();
        n_checks++; if (busy !== 1'b0 || serial_data !== 1'b1) begin n_fail++; $display("FAIL f7_return_idle: got busy=%b serial=%b expected 0/1", busy, serial_data); end
    endtask

    task automatic test_parity_extremes();
        logic [10:0] exp;
        logic [7:0]  d;
        for (int v = 0; v < 2; v++) begin
            d   = (v == 0) ? 8'h00 : 8'hFF;
            exp = (v == 0) ? 11'b11000000000 : 11'b11111111110;
            data_in = d;
            send = 1'b1;
            tick();
            send = 1'b0;
            for (int i = 0; i < 22; i++) begin
                tick();
                n_checks++; if (serial_data !== exp[i/2]) begin n_fail++; $display("FAIL parity_line d=%02h cycle %0d: got %b expected %b", d, i, serial_data, exp[i/2]); end
            end
            n_checks++; if (par !== 1'b1) begin n_fail++; $display("FAIL parity_par d=%02h: got %b expected 1", d, par); end
            tick();
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL parity_idle d=%02h: got busy=%b expected 0", d, busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] exp;
        logic        exp_rdy;
        int          lows;
        exp = {11'b11010101010, 11'b10111101110};
        data_in = 8'hF7;
        send = 1'b1;
        tick();
        send = 1'b0;
        for (int i = 0; i < 44; i++) begin
            tick();
            exp_rdy = !(i >= 3 && i <= 21);
            n_checks++; if (serial_data !== exp[i/2]) begin n_fail++; $display("FAIL b2b_line cycle %0d: got %b expected %b", i, serial_data, exp[i/2]); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy cycle %0d: got %b expected 1", i, busy); end
            n_checks++; if (ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready cycle %0d: got %b expected %b", i, ready, exp_rdy); end
            if (i == 0) begin
                n_checks++; if (par !== 1'b0) begin n_fail++; $display("FAIL b2b_par_first: got %b expected 0", par); end
            end
            if (i == 22) begin
                n_checks++; if (par !== 1'b1) begin n_fail++; $display("FAIL b2b_par_second: got %b expected 1", par); end
            end
            if (i == 2) begin send = 1'b1; data_in = 8'h55; end
            if (i == 3) send = 1'b0;
            if (i == 5) begin send = 1'b1; data_in = 8'hAA; end
            if (i == 6) begin send = 1'b0; data_in = 8'h33; end
        end
        tick();
        n_checks++; if (busy !== 1'b0 || serial_data !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got busy=%b serial=%b ready=%b expected 0/1/1", busy, serial_data, ready); end
        lows = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (serial_data !== 1'b1 || busy !== 1'b0) lows++;
        end
        n_checks++; if (lows != 0) begin n_fail++; $display("FAIL b2b_no_extra_frame: got %0d active cycles expected 0", lows); end
    endtask

    task automatic test_reset_mid_frame();
        int active;
        data_in = 8'hF7;
        send = 1'b1;
        tick();
        send = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 2) begin send = 1'b1; data_in = 8'h55; end
            if (i == 3) send = 1'b0;
        end
        n_checks++; if (serial_data !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL midrst_data_bit3: got serial=%b ready=%b expected 0/0", serial_data, ready); end
        rst = 1'b0;
        tick();
        n_checks++; if (serial_data !== 1'b1) begin n_fail++; $display("FAIL midrst_serial: got %b expected 1", serial_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", ready); end
        n_checks++; if (par !== 1'b0) begin n_fail++; $display("FAIL midrst_par: got %b expected 0", par); end
        rst = 1'b1;
        active = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (serial_data !== 1'b1 || busy !== 1'b0) active++;
        end
        n_checks++; if (active != 0) begin n_fail++; $display("FAIL midrst_no_resume: got %0d active cycles expected 0", active); end
    endtask

    task automatic test_clk1();
        logic [10:0] exp;
        exp = 11'b10000000010;
        data_in1 = 8'h01;
        send1 = 1'b1;
        tick();
        send1 = 1'b0;
        data_in1 = 8'hFF;
        for (int i = 0; i < 11; i++) begin
            tick();
            n_checks++; if (serial_data1 !== exp[i]) begin n_fail++; $display("FAIL clk1_line cycle %0d: got %b expected %b", i, serial_data1, exp[i]); end
            if (i == 0) begin
                n_checks++; if (par1 !== 1'b0) begin n_fail++; $display("FAIL clk1_par: got %b expected 0", par1); end
            end
        end
        tick();
        n_checks++; if (busy1 !== 1'b0 || serial_data1 !== 1'b1) begin n_fail++; $display("FAIL clk1_idle: got busy=%b serial=%b expected 0/1", busy1, serial_data1); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        send     = 1'b0;
        data_in  = 8'h00;
        send1    = 1'b0;
        data_in1 = 8'h00;
        test_reset();
        test_single_f7();
        test_parity_extremes();
        test_back_to_back();
        test_reset_mid_frame();
        test_clk1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
